braille_entry: RTL
==================

# braille_entry

Front-end input stage for the four-cell Braille display. It synchronises and debounces the four active-low push buttons and samples the 5-bit letter code from the switches. On each debounced press of button i, it stores the code in display cell i. The four registered cell codes feed the four per-digit Braille segment decoders directly, one code per HEX digit, so the display is stable and holds after the button is released.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a button level change (20 ms at 50 MHz); minimum 2
- CLOCK_50  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- SW  in  5  letter code: 0 = blank, 1..26 = A..Z, 27..31 invalid; asynchronous to CLOCK_50
- KEY  in  4  raw push buttons, active-low, bouncing; KEY[i] selects cell i
- cells  out  20  cell i code at cells[5i+4:5i], registered
- wr_pulse  out  4  one-cycle pulse, bit i set on the edge cell i is written
- err  out  1  one-cycle pulse: a press was accepted while the code was invalid

## Operation
- Synchronisation:
  - KEY passes through a 2-FF synchroniser, giving key_s.
  - SW passes through a separate 2-FF synchroniser, giving sw_s.
  - Both synchroniser chains reset to idle: KEY stages to 1, SW stages to 0.
- Per-button debounce, one instance per button:
  - State: stable level (reset 1) and counter cnt (reset 0).
  - Counter width: $clog2(DEBOUNCE_CYCLES).
  - If key_s == stable, cnt resets to 0.
  - Otherwise cnt increments. When key_s != stable and cnt == DEBOUNCE_CYCLES-1, stable takes key_s and cnt resets to 0.
  - Any single bounce sample back to the stable level restarts the count.
- Press event: stable goes from 1 to 0. Release (0 to 1) writes nothing and raises no flag.
- On a press event for button i:
  - If sw_s is 0..26: cell i takes sw_s and wr_pulse[i] is 1 for that cycle. Code 0 clears the cell to blank.
  - If sw_s is 27..31: cell i is unchanged and err pulses for one cycle.
- Simultaneous press events on several buttons are independent:
  - Every pressed cell is written with the same sw_s.
  - err is a single bit, set if any press in that cycle is rejected.
- Holding a button does not retrigger. Changing SW while a button is held has no effect.
- Reset mid-debounce discards the pending count; no write occurs.

## Timing
- Reset values:
  - cells = 0 (all blank)
  - wr_pulse = 0
  - err = 0
  - all stable = 1
  - all cnt = 0
- Latency: KEY[i] is held low cleanly from its first sampled edge, E0. It reaches key_s after 2 edges. stable falls, cells is written and wr_pulse[i] rises, all on edge E0+1+DEBOUNCE_CYCLES.
- The code written is sw_s as seen in the cycle before that edge. SW must be steady for at least 3 cycles before the accept edge.
- wr_pulse and err are high for exactly one cycle per event.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package braille_pkg:
  - LETTER_W = 5, NUM_CELLS = 4
  - CODE_BLANK = 0, CODE_MIN = 1, CODE_MAX = 26
  - function code_valid(code): true when code <= CODE_MAX
- Sub-module key_debounce: single-bit synchroniser, stable/counter pair and press-pulse output, parameterised by DEBOUNCE_CYCLES. It is instantiated NUM_CELLS times.
- The top level holds the SW synchroniser, the validity check, the cell registers and the pulse registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Reset: pulse RST_N low mid-run with cells = 0x12345. Required: cells = 0, wr_pulse = 0 and err = 0 immediately (asynchronously), and they stay there after release.
- Clean press: SW = 3, KEY[0] goes low at edge E0. Required: cells[4:0] = 3 and wr_pulse = 4'b0001 at edge E0+5 only; other cells stay 0. Releasing the button changes nothing.
- Bounce: KEY[1] toggles low/high every 2 cycles for 20 cycles, then is held low, with SW = 26. Required: exactly one write, cells[9:5] = 26, one wr_pulse[1], which fires 5 edges after the final low level first reaches the input.
- Invalid code: SW = 30, press KEY[2]. Required: one err pulse, wr_pulse = 0, cells[14:10] unchanged. Then set SW = 0, release and press again. Required: cell 2 is blanked to 0.
- Simultaneous: SW = 8, KEY[3] and KEY[0] go low on the same edge. Required: cells[19:15] = 8 and cells[4:0] = 8 on the same edge, wr_pulse = 4'b1001.
- Hold / reset mid-debounce:
  - Hold KEY[0] low for 50 cycles while SW changes 5 → 9 after the accept edge. Required: cell 0 stays 5 and no further pulses.
  - Assert RST_N 2 cycles into a fresh press. Required: no write, and all cells 0.

Source files
------------

// File: rtl/braille_pkg.sv
// ---------------------------------------------------------------------------
// braille_pkg
// Shared definitions for the Braille entry front end: letter code width,
// number of display cells, code range limits and the code validity check.
// ---------------------------------------------------------------------------
package braille_pkg;

    localparam int LETTER_W  = 5;
    localparam int NUM_CELLS = 4;

    typedef logic [LETTER_W-1:0] code_t;

    localparam code_t CODE_BLANK = 5'd0;
    localparam code_t CODE_MIN   = 5'd1;
    localparam code_t CODE_MAX   = 5'd26;

    // Blank or a letter A..Z is writable; 27..31 are rejected.
    function automatic logic code_valid(input code_t code);
        return (code == CODE_BLANK) || ((code >= CODE_MIN) && (code <= CODE_MAX));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One push button: 2-FF synchroniser, stable-level/counter debouncer and a
// press strobe that is high in the cycle before the debounced level falls.
//
// Ports
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset
//   key_ni   raw active-low button, asynchronous and bouncing
//   press_o  high for one cycle; the stable level falls on the following edge
// ---------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             key_s;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    assign key_s  = sync_q[1];
    assign accept = (key_s != stable_q) && (cnt_q == CNT_MAX);

    // Any sample equal to the stable level restarts the count, so only an
    // unbroken run of differing samples can flip the stable level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (key_s != stable_q) begin
            if (accept) begin
                stable_d = key_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], key_ni};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Only the 1 -> 0 transition is a press; releases are silent.
    assign press_o = accept && stable_q;

endmodule

// File: rtl/braille_entry.sv
// ---------------------------------------------------------------------------
// braille_entry
// Input stage of the four-cell Braille display. Each debounced press of
// KEY[i] stores the synchronised switch code in cell i, or flags an error if
// the code is not a letter or blank. Cells hold until overwritten or reset.
//
// Ports
//   CLOCK_50  system clock
//   RST_N     asynchronous active-low reset
//   SW        5-bit letter code (0 blank, 1..26 A..Z), asynchronous
//   KEY       4 raw active-low push buttons, KEY[i] selects cell i
//   cells     registered cell codes, cell i at cells[5i+4:5i]
//   wr_pulse  one-cycle strobe per written cell
//   err       one-cycle strobe when a press met an invalid code
// ---------------------------------------------------------------------------
module braille_entry
    import braille_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                          CLOCK_50,
    input  logic                          RST_N,
    input  logic [LETTER_W-1:0]           SW,
    input  logic [NUM_CELLS-1:0]          KEY,
    output logic [NUM_CELLS*LETTER_W-1:0] cells,
    output logic [NUM_CELLS-1:0]          wr_pulse,
    output logic                          err
);

    code_t                       sw_meta_q, sw_s_q;
    logic [NUM_CELLS-1:0]        press;
    code_t [NUM_CELLS-1:0]       cell_q, cell_d;
    logic [NUM_CELLS-1:0]        wr_q, wr_d;
    logic                        err_q, err_d;
    logic                        sw_ok;

    for (genvar i = 0; i < NUM_CELLS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk_i  (CLOCK_50),
            .rst_ni (RST_N),
            .key_ni (KEY[i]),
            .press_o(press[i])
        );
    end

    assign sw_ok = code_valid(sw_s_q);

    // Simultaneous presses all take the same code; one shared error flag.
    always_comb begin
        cell_d = cell_q;
        wr_d   = '0;
        err_d  = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (press[i]) begin
                if (sw_ok) begin
                    cell_d[i] = sw_s_q;
                    wr_d[i]   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            sw_meta_q <= CODE_BLANK;
            sw_s_q    <= CODE_BLANK;
            cell_q    <= {NUM_CELLS{CODE_BLANK}};
            wr_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            sw_meta_q <= SW;
            sw_s_q    <= sw_meta_q;
            cell_q    <= cell_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
        end
    end

    assign cells    = cell_q;
    assign wr_pulse = wr_q;
    assign err      = err_q;

endmodule
